// File: rtl/reg_hazard_ctrl_if.sv
// Decode-side hazard/forwarding bundle between the pipeline control and reg_hazard_ctrl.
// The master drives the ID-stage fields; the slave returns stall, read selects and write strobes.
interface reg_hazard_ctrl_if #(
    parameter int unsigned REG_NUM_WIDTH     = 4,
    parameter int unsigned REG_FORWARD_WIDTH = 2
);
    logic                         id_valid;
    logic [REG_NUM_WIDTH-1:0]     id_rn_1;
    logic [REG_NUM_WIDTH-1:0]     id_rn_2;
    logic                         id_use_1;
    logic                         id_use_2;
    logic                         id_wr;
    logic [REG_NUM_WIDTH-1:0]     id_wrn;
    logic                         id_wr0;
    logic                         stall;
    logic [REG_FORWARD_WIDTH-1:0] reg_forward_1;
    logic [REG_FORWARD_WIDTH-1:0] reg_forward_2;
    logic                         wr;
    logic [REG_NUM_WIDTH-1:0]     wrn;
    logic                         wr0;
    logic                         mdu_busy;

    modport master (
        output id_valid, id_rn_1, id_rn_2, id_use_1, id_use_2, id_wr, id_wrn, id_wr0,
        input  stall, reg_forward_1, reg_forward_2, wr, wrn, wr0, mdu_busy
    );

    modport slave (
        input  id_valid, id_rn_1, id_rn_2, id_use_1, id_use_2, id_wr, id_wrn, id_wr0,
        output stall, reg_forward_1, reg_forward_2, wr, wrn, wr0, mdu_busy
    );
endinterface

// File: rtl/reg_hazard_ctrl.sv
// Hazard detection and forwarding control for a 3-stage ID->EX->WB pipeline with a
// 16-entry register file and a multi-cycle R0 writer (multiply/divide unit).
module reg_hazard_ctrl #(
    parameter int unsigned                   REG_NUM_WIDTH        = 4,
    parameter int unsigned                   REG_FORWARD_WIDTH    = 2,
    parameter logic [REG_FORWARD_WIDTH-1:0]  REG_FORWARD_REG_FILE = 2'b00,
    parameter logic [REG_FORWARD_WIDTH-1:0]  REG_FORWARD_WB       = 2'b01,
    parameter logic [REG_FORWARD_WIDTH-1:0]  REG_FORWARD_R0       = 2'b10,
    parameter int unsigned                   MDU_LATENCY          = 4
) (
    input logic              clk,
    input logic              rst_n,
    reg_hazard_ctrl_if.slave hz
);
    localparam logic [3:0] CntOne  = 4'd1;
    localparam logic [3:0] CntLoad = 4'(MDU_LATENCY);

    logic                     ex_valid_q;
    logic                     ex_wr_q;
    logic [REG_NUM_WIDTH-1:0] ex_wrn_q;
    logic                     wr_q;
    logic [REG_NUM_WIDTH-1:0] wrn_q;
    logic [3:0]               mdu_cnt_q;
    logic [3:0]               mdu_cnt_d;
    logic                     wr0_q;
    logic                     mdu_busy_q;

    logic                         accept;
    logic                         src_stall;
    logic                         struct_stall;
    logic                         waw_stall;
    logic                         stall;
    logic [REG_NUM_WIDTH-1:0]     rn [2];
    logic                         use_src [2];
    logic [REG_FORWARD_WIDTH-1:0] fwd [2];

    // Per-source RAW detection and forwarding select; R0 completion beats a WB match.
    always_comb begin
        rn[0]      = hz.id_rn_1;
        rn[1]      = hz.id_rn_2;
        use_src[0] = hz.id_valid & hz.id_use_1;
        use_src[1] = hz.id_valid & hz.id_use_2;
        src_stall  = 1'b0;
        fwd[0]     = REG_FORWARD_REG_FILE;
        fwd[1]     = REG_FORWARD_REG_FILE;
        for (int i = 0; i < 2; i++) begin
            if (use_src[i]) begin
                if ((ex_valid_q && ex_wr_q && (ex_wrn_q == rn[i])) ||
                    ((rn[i] == '0) && (mdu_cnt_q > CntOne))) begin
                    src_stall = 1'b1;
                end
                if ((rn[i] == '0) && (mdu_cnt_q == CntOne)) begin
                    fwd[i] = REG_FORWARD_R0;
                end else if (wr_q && (wrn_q == rn[i])) begin
                    fwd[i] = REG_FORWARD_WB;
                end
            end
        end
    end

    always_comb begin
        struct_stall = hz.id_valid & hz.id_wr0 & (mdu_cnt_q > CntOne);
        // Keeps a WB write to R0 from ever colliding with the wr0 strobe.
        waw_stall    = hz.id_valid & hz.id_wr & (hz.id_wrn == '0) & (mdu_cnt_q != 4'd0);
        stall        = src_stall | struct_stall | waw_stall;
        accept       = hz.id_valid & ~stall;
    end

    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (accept && hz.id_wr0) begin
            mdu_cnt_d = CntLoad;
        end else if (mdu_cnt_q != 4'd0) begin
            mdu_cnt_d = mdu_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_wr_q    <= 1'b0;
            ex_wrn_q   <= '0;
            wr_q       <= 1'b0;
            wrn_q      <= '0;
            mdu_cnt_q  <= 4'd0;
            wr0_q      <= 1'b0;
            mdu_busy_q <= 1'b0;
        end else begin
            ex_valid_q <= accept;
            ex_wr_q    <= accept & hz.id_wr;
            if (accept) begin
                ex_wrn_q <= hz.id_wrn;
            end
            wr_q       <= ex_valid_q & ex_wr_q;
            wrn_q      <= ex_wrn_q;
            mdu_cnt_q  <= mdu_cnt_d;
            wr0_q      <= (mdu_cnt_d == CntOne);
            mdu_busy_q <= (mdu_cnt_d != 4'd0);
        end
    end

    assign hz.stall         = stall;
    assign hz.reg_forward_1 = fwd[0];
    assign hz.reg_forward_2 = fwd[1];
    assign hz.wr            = wr_q;
    assign hz.wrn           = wrn_q;
    assign hz.wr0           = wr0_q;
    assign hz.mdu_busy      = mdu_busy_q;

endmodule

// File: tb/tb_reg_hazard_ctrl.sv
// Directed bench for reg_hazard_ctrl: RAW stalls, WB/R0 forwarding, R0 writer sequencing, reset.
module tb_reg_hazard_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    reg_hazard_ctrl_if #(.REG_NUM_WIDTH(4), .REG_FORWARD_WIDTH(2)) hz ();

    reg_hazard_ctrl #(.MDU_LATENCY(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] rn1, input logic u1,
                         input logic [3:0] rn2, input logic u2, input logic w,
                         input logic [3:0] wn, input logic w0);
        hz.id_valid = v;
        hz.id_rn_1  = rn1;
        hz.id_use_1 = u1;
        hz.id_rn_2  = rn2;
        hz.id_use_2 = u2;
        hz.id_wr    = w;
        hz.id_wrn   = wn;
        hz.id_wr0   = w0;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #8;
        checks++; if (hz.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got %b want 0", hz.stall); end
        checks++; if (hz.wr !== 1'b0) begin failures++; $display("FAIL reset_wr got %b want 0", hz.wr); end
        checks++; if (hz.wrn !== 4'd0) begin failures++; $display("FAIL reset_wrn got %0d want 0", hz.wrn); end
        checks++; if (hz.wr0 !== 1'b0) begin failures++; $display("FAIL reset_wr0 got %b want 0", hz.wr0); end
        checks++; if (hz.mdu_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", hz.mdu_busy); end
        checks++; if ({hz.reg_forward_1, hz.reg_forward_2} !== 4'b0000) begin failures++;
            $display("FAIL reset_fwd got %b want 0000", {hz.reg_forward_1, hz.reg_forward_2}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_raw_back_to_back();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0);
        checks++; if (hz.stall !== 1'b0) begin failures++; $display("FAIL raw_prod_stall got %b want 0", hz.stall); end
        tick();
        drive(1'b1, 4'd3, 1'b1, 4'd9, 1'b0, 1'b0, 4'd0, 1'b0);
        checks++; if (hz.stall !== 1'b1) begin failures++; $display("FAIL raw_ex_stall got %b want 1", hz.stall); end
        tick();
        #2;
        checks++; if (hz.stall !== 1'b0) begin failures++; $display("FAIL raw_release_stall got %b want 0", hz.stall); end
        checks++; if (hz.reg_forward_1 !== 2'b01) begin failures++; $display("FAIL raw_fwd1 got %b want 01", hz.reg_forward_1); end
        checks++; if (hz.wr !== 1'b1) begin failures++; $display("FAIL raw_wr got %b want 1", hz.wr); end
        checks++; if (hz.wrn !== 4'd3) begin failures++; $display("FAIL raw_wrn got %0d want 3", hz.wrn); end
        tick();
        idle();
        tick();
        tick();
    endtask

    task automatic test_wb_forward();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0);
        tick();
        drive(1'b1, 4'd7, 1'b0, 4'd8, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        drive(1'b1, 4'd5, 1'b0, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0);
        checks++; if (hz.stall !== 1'b0) begin failures++; $display("FAIL d2_stall got %b want 0", hz.stall); end
        checks++; if (hz.reg_forward_2 !== 2'b01) begin failures++; $display("FAIL d2_fwd2 got %b want 01", hz.reg_forward_2); end
        checks++; if (hz.reg_forward_1 !== 2'b00) begin failures++; $display("FAIL d2_fwd1 got %b want 00", hz.reg_forward_1); end
        tick();
        #2;
        checks++; if (hz.stall !== 1'b0) begin failures++; $display("FAIL d3_stall got %b want 0", hz.stall); end
        checks++; if (hz.reg_forward_2 !== 2'b00) begin failures++; $display("FAIL d3_fwd2 got %b want 00", hz.reg_forward_2); end
        tick();
        idle();
        tick();
        tick();
    endtask

    task automatic test_r0_latency();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
        checks++; if (hz.stall !== 1'b0) begin failures++; $display("FAIL r0_issue_stall got %b want 0", hz.stall); end
        tick();
        drive(1'b1, 4'd0, 1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks++; if (hz.stall !== 1'b1) begin failures++; $display("FAIL r0_pend_stall[%0d] got %b want 1", k, hz.stall); end
            checks++; if (hz.wr0 !== 1'b0) begin failures++; $display("FAIL r0_pend_wr0[%0d] got %b want 0", k, hz.wr0); end
            checks++; if (hz.mdu_busy !== 1'b1) begin failures++; $display("FAIL r0_pend_busy[%0d] got %b want 1", k, hz.mdu_busy); end
            tick();
            #2;
        end
        checks++; if (hz.stall !== 1'b0) begin failures++; $display("FAIL r0_done_stall got %b want 0", hz.stall); end
        checks++; if (hz.wr0 !== 1'b1) begin failures++; $display("FAIL r0_done_wr0 got %b want 1", hz.wr0); end
        checks++; if (hz.reg_forward_1 !== 2'b10) begin failures++; $display("FAIL r0_done_fwd1 got %b want 10", hz.reg_forward_1); end
        tick();
        idle();
        checks++; if (hz.wr0 !== 1'b0) begin failures++; $display("FAIL r0_after_wr0 got %b want 0", hz.wr0); end
        checks++; if (hz.mdu_busy !== 1'b0) begin failures++; $display("FAIL r0_after_busy got %b want 0", hz.mdu_busy); end
        tick();
    endtask

    task automatic test_back_to_back_r0();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
        tick();
        idle();
        tick();
        // Counter now at 3: second R0 op must wait for the completion cycle.
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            checks++; if (hz.stall !== 1'b1) begin failures++; $display("FAIL struct_stall[%0d] got %b want 1", k, hz.stall); end
            tick();
            #2;
        end
        checks++; if (hz.stall !== 1'b0) begin failures++; $display("FAIL struct_accept_stall got %b want 0", hz.stall); end
        checks++; if (hz.wr0 !== 1'b1) begin failures++; $display("FAIL struct_accept_wr0 got %b want 1", hz.wr0); end
        tick();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0);
        checks++; if (hz.mdu_busy !== 1'b1) begin failures++; $display("FAIL reload_busy got %b want 1", hz.mdu_busy); end
        checks++; if (hz.wr0 !== 1'b0) begin failures++; $display("FAIL reload_wr0 got %b want 0", hz.wr0); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (hz.stall !== 1'b1) begin failures++; $display("FAIL waw_stall[%0d] got %b want 1", k, hz.stall); end
            tick();
            #2;
        end
        checks++; if (hz.stall !== 1'b0) begin failures++; $display("FAIL waw_accept_stall got %b want 0", hz.stall); end
        checks++; if (hz.mdu_busy !== 1'b0) begin failures++; $display("FAIL waw_accept_busy got %b want 0", hz.mdu_busy); end
        tick();
        idle();
        tick();
        checks++; if ({hz.wr, hz.wrn, hz.wr0} !== {1'b1, 4'd0, 1'b0}) begin failures++;
            $display("FAIL waw_wb got wr=%b wrn=%0d wr0=%b want wr=1 wrn=0 wr0=0", hz.wr, hz.wrn, hz.wr0); end
        tick();
    endtask

    task automatic test_unused_source();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0);
        tick();
        drive(1'b1, 4'd5, 1'b0, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0);
        checks++; if (hz.stall !== 1'b0) begin failures++; $display("FAIL unused_stall got %b want 0", hz.stall); end
        checks++; if (hz.reg_forward_1 !== 2'b00) begin failures++; $display("FAIL unused_fwd1 got %b want 00", hz.reg_forward_1); end
        drive(1'b0, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0);
        checks++; if (hz.stall !== 1'b0) begin failures++; $display("FAIL novalid_stall got %b want 0", hz.stall); end
        tick();
        #2;
        checks++; if (hz.reg_forward_2 !== 2'b00) begin failures++; $display("FAIL novalid_fwd2 got %b want 00", hz.reg_forward_2); end
        idle();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_op();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b1);
        tick();
        idle();
        tick();
        checks++; if ({hz.wr, hz.mdu_busy} !== 2'b11) begin failures++;
            $display("FAIL premid_state got wr=%b busy=%b want 1 1", hz.wr, hz.mdu_busy); end
        rst_n = 1'b0;
        #1;
        checks++; if ({hz.wr, hz.wr0, hz.mdu_busy, hz.stall} !== 4'b0000) begin failures++;
            $display("FAIL midreset_outs got wr=%b wr0=%b busy=%b stall=%b want 0", hz.wr, hz.wr0, hz.mdu_busy, hz.stall); end
        checks++; if (hz.wrn !== 4'd0) begin failures++; $display("FAIL midreset_wrn got %0d want 0", hz.wrn); end
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (hz.wr0 !== 1'b0) begin failures++; $display("FAIL postreset_wr0[%0d] got %b want 0", k, hz.wr0); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_raw_back_to_back();
        test_wb_forward();
        test_r0_latency();
        test_back_to_back_r0();
        test_unused_source();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
